// File: rtl/captura_veiculo.sv
// Vehicle capture front end for the toll charging block: debounces the loop and axle
// treadle, counts axles, tracks peak weight. Optional macro TIMEOUT_EN aborts long passages.
module captura_veiculo #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int READY_CICLOS    = 2,
  parameter int TIMEOUT_CICLOS  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_laco,
  input  logic       sensor_eixo,
  input  logic [7:0] peso_bruto,
  output logic [1:0] Eixos,
  output logic [3:0] Peso,
  output logic       ready,
  output logic       erro,
  output logic       ocupado
);

  localparam logic [3:0] DB_LIM  = 4'(DEBOUNCE_CICLOS);
  localparam logic [3:0] RDY_LIM = 4'(READY_CICLOS);

  typedef enum logic [1:0] {IDLE, PRESENCA, AVALIA, ENVIA} estado_t;
  estado_t state, state_d;

  logic       laco_s_p0, laco_s_p1, eixo_s_p0, eixo_s_p1;
  logic       laco_deb, eixo_deb, laco_deb_q, eixo_deb_q;
  logic [3:0] laco_cnt, eixo_cnt;
  logic [2:0] cnt_eixo;
  logic [7:0] peso_max;
  logic [3:0] rdy_cnt;
  logic       laco_rise, laco_fall, eixo_rise, tmo_hit;

  function automatic logic [3:0] peso_ton(input logic [7:0] p);
    logic [8:0] q;
    q = ({1'b0, p} + 9'd9) / 9'd10;
    return (q > 9'd15) ? 4'd15 : q[3:0];
  endfunction

  function automatic logic [1:0] cod_eixos(input logic [2:0] n);
    logic [2:0] d;
    d = n - 3'd2;
    return (n >= 3'd5) ? 2'd3 : d[1:0];
  endfunction

  // Synchroniser + debounce stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      laco_s_p0  <= 1'b0;
      laco_s_p1  <= 1'b0;
      eixo_s_p0  <= 1'b0;
      eixo_s_p1  <= 1'b0;
      laco_deb   <= 1'b0;
      eixo_deb   <= 1'b0;
      laco_deb_q <= 1'b0;
      eixo_deb_q <= 1'b0;
      laco_cnt   <= 4'd0;
      eixo_cnt   <= 4'd0;
    end else begin
      laco_s_p0  <= sensor_laco;
      laco_s_p1  <= laco_s_p0;
      eixo_s_p0  <= sensor_eixo;
      eixo_s_p1  <= eixo_s_p0;
      laco_deb_q <= laco_deb;
      eixo_deb_q <= eixo_deb;
      if (laco_s_p1 != laco_deb) begin
        if (laco_cnt == DB_LIM - 4'd1) begin
          laco_deb <= laco_s_p1;
          laco_cnt <= 4'd0;
        end else begin
          laco_cnt <= laco_cnt + 4'd1;
        end
      end else begin
        laco_cnt <= 4'd0;
      end
      if (eixo_s_p1 != eixo_deb) begin
        if (eixo_cnt == DB_LIM - 4'd1) begin
          eixo_deb <= eixo_s_p1;
          eixo_cnt <= 4'd0;
        end else begin
          eixo_cnt <= eixo_cnt + 4'd1;
        end
      end else begin
        eixo_cnt <= 4'd0;
      end
    end
  end

  assign laco_rise = laco_deb & ~laco_deb_q;
  assign laco_fall = ~laco_deb & laco_deb_q;
  assign eixo_rise = eixo_deb & ~eixo_deb_q;

`ifdef TIMEOUT_EN
  logic [15:0] tmo_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tmo_cnt <= 16'd0;
    else if (state == PRESENCA) tmo_cnt <= tmo_cnt + 16'd1;
    else                       tmo_cnt <= 16'd0;
  end
  assign tmo_hit = (state == PRESENCA) && !laco_fall && (tmo_cnt == 16'(TIMEOUT_CICLOS - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (laco_rise) state_d = PRESENCA;
      PRESENCA: begin
        if (laco_fall)    state_d = AVALIA;
        else if (tmo_hit) state_d = IDLE;
      end
      AVALIA:   state_d = (cnt_eixo < 3'd2) ? IDLE : ENVIA;
      ENVIA:    if (rdy_cnt == RDY_LIM - 4'd1) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign ready   = (state == ENVIA);
  assign ocupado = (state != IDLE);

  // Capture / evaluation stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_eixo <= 3'd0;
      peso_max <= 8'd0;
      rdy_cnt  <= 4'd0;
      Eixos    <= 2'd0;
      Peso     <= 4'd0;
      erro     <= 1'b0;
    end else begin
      erro    <= ((state == AVALIA) && (cnt_eixo < 3'd2)) || tmo_hit;
      rdy_cnt <= (state == ENVIA) ? rdy_cnt + 4'd1 : 4'd0;
      case (state)
        IDLE: if (laco_rise) begin
          cnt_eixo <= 3'd0;
          peso_max <= 8'd0;
        end
        PRESENCA: begin
          if (eixo_rise && (cnt_eixo != 3'd7)) cnt_eixo <= cnt_eixo + 3'd1;
          if (peso_bruto > peso_max)           peso_max <= peso_bruto;
        end
        AVALIA: if (cnt_eixo >= 3'd2) begin
          Eixos <= cod_eixos(cnt_eixo);
          Peso  <= peso_ton(peso_max);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_veiculo.sv
// Directed bench for captura_veiculo: whole vehicle passages with hand-computed results.
module tb_captura_veiculo;
  logic       clk = 1'b0;
  logic       reset, sensor_laco, sensor_eixo;
  logic [7:0] peso_bruto;
  logic [1:0] Eixos;
  logic [3:0] Peso;
  logic       ready, erro, ocupado;

  int errors = 0, checks = 0;
  int rdy_cyc = 0, rdy_rise = 0, err_cyc = 0;
  logic       ready_q = 1'b0;
  logic [1:0] eix_at = 2'd0;
  logic [3:0] peso_at = 4'd0;

  always #5 clk = ~clk;

`ifdef TIMEOUT_EN
  captura_veiculo #(.DEBOUNCE_CICLOS(4), .READY_CICLOS(2), .TIMEOUT_CICLOS(50)) dut (
`else
  captura_veiculo #(.DEBOUNCE_CICLOS(4), .READY_CICLOS(2), .TIMEOUT_CICLOS(1000)) dut (
`endif
    .clk(clk), .reset(reset), .sensor_laco(sensor_laco), .sensor_eixo(sensor_eixo),
    .peso_bruto(peso_bruto), .Eixos(Eixos), .Peso(Peso), .ready(ready), .erro(erro),
    .ocupado(ocupado));

  always @(negedge clk) begin
    if (ready) rdy_cyc++;
    if (ready && !ready_q) begin
      rdy_rise++;
      eix_at  = Eixos;
      peso_at = Peso;
    end
    ready_q = ready;
    if (erro) err_cyc++;
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic eixo_pulso();
    sensor_eixo = 1'b1;
    ciclos(8);
    sensor_eixo = 1'b0;
    ciclos(8);
  endtask

  // n axle pulses; weight p0 at loop rise, p1 after first pulse, p2 after second.
  task automatic veiculo(input string tag, input int n, input int p0, input int p1, input int p2,
                         input bit glitch, input int exp_e, input int exp_p, input bit exp_ok);
    int r0, rr0, e0;
    r0 = rdy_cyc; rr0 = rdy_rise; e0 = err_cyc;
    peso_bruto  = 8'(p0);
    sensor_laco = 1'b1;
    ciclos(12);
    chk({tag, "_ocupado"}, int'(ocupado), 1);
    for (int i = 0; i < n; i++) begin
      eixo_pulso();
      if (i == 0) peso_bruto = 8'(p1);
      if (i == 1) peso_bruto = 8'(p2);
      if (i == 0 && glitch) begin
        sensor_eixo = 1'b1;
        ciclos(2);
        sensor_eixo = 1'b0;
        ciclos(8);
      end
    end
    ciclos(4);
    sensor_laco = 1'b0;
    ciclos(30);
    chk({tag, "_ready_rise"}, rdy_rise - rr0, exp_ok ? 1 : 0);
    chk({tag, "_ready_ciclos"}, rdy_cyc - r0, exp_ok ? 2 : 0);
    chk({tag, "_erro"}, err_cyc - e0, exp_ok ? 0 : 1);
    chk({tag, "_Eixos"}, int'(Eixos), exp_e);
    chk({tag, "_Peso"}, int'(Peso), exp_p);
    if (exp_ok) begin
      chk({tag, "_Eixos_no_ready"}, int'(eix_at), exp_e);
      chk({tag, "_Peso_no_ready"}, int'(peso_at), exp_p);
    end
    chk({tag, "_livre"}, int'(ocupado), 0);
  endtask

  initial begin
    int r0, e0;
    reset = 1'b0; sensor_laco = 1'b0; sensor_eixo = 1'b0; peso_bruto = 8'd0;
    ciclos(3);
    chk("rst_Eixos", int'(Eixos), 0);
    chk("rst_Peso", int'(Peso), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    reset = 1'b1;
    ciclos(5);

    veiculo("v2eixos", 2, 65, 65, 65, 1'b0, 0, 7, 1'b1);
    veiculo("v3rampa", 3, 40, 120, 90, 1'b0, 1, 12, 1'b1);
    veiculo("v6sat", 6, 200, 200, 200, 1'b0, 3, 15, 1'b1);
    veiculo("v1erro", 1, 50, 50, 50, 1'b0, 3, 15, 1'b0);

    // Reset in the middle of a passage
    sensor_laco = 1'b1; peso_bruto = 8'd50;
    ciclos(12);
    eixo_pulso();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_Eixos", int'(Eixos), 0);
    chk("rmid_Peso", int'(Peso), 0);
    chk("rmid_ready", int'(ready), 0);
    chk("rmid_erro", int'(erro), 0);
    chk("rmid_ocupado", int'(ocupado), 0);
    sensor_laco = 1'b0;
    ciclos(3);
    reset = 1'b1;
    r0 = rdy_cyc; e0 = err_cyc;
    ciclos(30);
    chk("rpos_ready", rdy_cyc - r0, 0);
    chk("rpos_erro", err_cyc - e0, 0);
    chk("rpos_ocupado", int'(ocupado), 0);

    veiculo("vglitch", 2, 71, 71, 71, 1'b1, 0, 8, 1'b1);
    veiculo("v4eixos", 4, 100, 100, 100, 1'b0, 2, 10, 1'b1);

`ifdef TIMEOUT_EN
    r0 = rdy_cyc; e0 = err_cyc;
    sensor_laco = 1'b1;
    ciclos(70);
    chk("tmo_erro", err_cyc - e0, 1);
    chk("tmo_ready", rdy_cyc - r0, 0);
    chk("tmo_ocupado", int'(ocupado), 0);
    sensor_laco = 1'b0;
    ciclos(20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/captura_veiculo.md
Name: captura_veiculo

Overview:
- Upstream stage of the toll charging block.
- Watches the lane presence loop and the axle treadle, and samples the scale while a vehicle is over the sensors.
- When the vehicle leaves, emits axle code Eixos[1:0], weight Peso[3:0] in whole tonnes, and a ready pulse that the charging block consumes on its rising edge.
- Malformed passages raise erro instead of ready.

Parameters:
- DEBOUNCE_CICLOS, 4: consecutive stable samples required before a sensor_eixo or sensor_laco level change is accepted (1..15).
- READY_CICLOS, 2: number of cycles ready is held high per vehicle (1..15).
- TIMEOUT_CICLOS, 1000: maximum cycles in PRESENCA before abort; used only with TIMEOUT_EN (width 16 bits).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- sensor_laco, input, 1: raw presence loop, 1 = vehicle over lane.
- sensor_eixo, input, 1: raw axle treadle, 1 = axle on treadle.
- peso_bruto, input, 8: scale reading in units of 100 kg (0..255).
- Eixos, output, 2: 00 = 2 axles, 01 = 3, 10 = 4, 11 = 5 or more.
- Peso, output, 4: weight in tonnes, rounded up, saturated at 15.
- ready, output, 1: high for READY_CICLOS cycles when a valid capture completes.
- erro, output, 1: one-cycle pulse on an invalid passage.
- ocupado, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous): Eixos = 00, Peso = 0, ready = 0, erro = 0, ocupado = 0, FSM = IDLE, all counters 0, debounced levels 0. Reset mid-capture discards the vehicle; no ready is issued.
- Debounce: each raw input passes a 2-flop synchroniser, then a counter. The debounced level changes only after DEBOUNCE_CICLOS consecutive samples differ from it. Edge detection runs on debounced levels only.
- Axle counting: a 3-bit saturating counter increments on each debounced rising edge of sensor_eixo while in PRESENCA. It saturates at 7.
- Weight sampling: an 8-bit register peso_max, cleared on entry to PRESENCA, updates each PRESENCA cycle to max(peso_max, peso_bruto).
- IDLE:
  - ocupado = 0.
  - Debounced rise of sensor_laco -> PRESENCA; clear the axle counter and peso_max.
  - A debounced axle edge in IDLE is ignored.
- PRESENCA:
  - Count axles and sample weight.
  - Debounced fall of sensor_laco -> AVALIA.
  - A simultaneous axle rise and loop fall on the same cycle: the axle is counted.
- AVALIA (1 cycle):
  - Axle count < 2: pulse erro for 1 cycle, go to IDLE, leave Eixos/Peso unchanged.
  - Otherwise:
    - Eixos = min(count, 5) - 2.
    - Peso = min(15, ceil(peso_max / 10)); e.g. 70 -> 7, 71 -> 8, 121 -> 13, 200 -> 15.
    - Go to ENVIA.
- ENVIA:
  - ready = 1 for exactly READY_CICLOS cycles, then go to IDLE.
  - Eixos/Peso are stable from the first ready cycle and hold until the next AVALIA that succeeds.
- ready spacing: IDLE lasts at least 1 cycle, so ready always returns low before the next vehicle. Consecutive vehicles therefore always produce distinct rising edges downstream.
- Loop reasserted during ENVIA: not seen until IDLE. The debounced level is still high in IDLE, so it must fall and rise again before a new capture. A vehicle that never clears the loop is not recaptured.
- Latency: ready rises 2 cycles after the debounced loop fall (AVALIA, then the first ENVIA cycle).

Optional Feature:
- TIMEOUT_EN defined:
  - A 16-bit counter runs in PRESENCA.
  - Reaching TIMEOUT_CICLOS -> pulse erro, go to IDLE, no ready.
  - Re-arm requires a debounced loop fall then rise.
- TIMEOUT_EN undefined: no counter; PRESENCA waits indefinitely. The TIMEOUT_CICLOS parameter is accepted but unused.

Test Plan:
- Loop high, 2 axle pulses, peso_bruto = 65, loop low -> Eixos = 00, Peso = 7, ready high 2 cycles, erro = 0.
- Loop high, 3 axle pulses, peso_bruto ramps 40 -> 120 -> 90, loop low -> Eixos = 01, Peso = 12 (max 120 used).
- 6 axle pulses, peso_bruto = 200 -> Eixos = 11, Peso = 15 (saturated).
- 1 axle pulse, then loop low -> erro pulses 1 cycle, ready stays 0, Eixos/Peso keep the previous vehicle's values.
- Axle input glitch shorter than DEBOUNCE_CICLOS within 2 real pulses -> count stays 2 (Eixos = 00).
- reset = 0 during PRESENCA -> all outputs 0 immediately. After release, no ready until a fresh loop rise/fall.
- With TIMEOUT_EN and TIMEOUT_CICLOS = 50, loop held 60 cycles -> erro at cycle 50, no ready.
